envelope_ramp12: RTL
====================

# envelope_ramp12

Per-voice envelope datapath. Consumes the phase code from `ENVELOPE_CTRL12` and produces the 12-bit `volume` that the controller reads back. It also applies that volume to the voice's oscillator sample, and the result feeds one `channelN` input of `MIXER12_MONO`. All volume updates happen on the 16 kHz `new_sample` tick; the gain path runs at the system clock.

## Interface
Parameters:
- `VOL_MAX`, 12'h7FF, attack ceiling; must equal the controller's maximum volume.
- `RATE_W`, 8, width of the rate-divider fields.

Ports:
- `CLK`  in  1  system clock; the only clock.
- `RST`  in  1  reset; synchronous, active-high.
- `new_sample`  in  1  one-cycle 16 kHz tick.
- `state`  in  3  phase code from controller: 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE, 5 BLANK.
- `attack_rate`, `decay_rate`, `release_rate`  in  RATE_W each  ticks per step, minus one.
- `attack_step`, `decay_step`, `release_step`  in  8 each  volume change per step.
- `sustain_value`  in  12  sustain level; the same signal that drives the controller.
- `volume`  out  12  envelope level, registered.
- `step_tick`  out  1  one-cycle pulse when a ramp step is applied.
- `sample_i`  in  12  unsigned oscillator sample.
- `sample_valid_i`  in  1  qualifies `sample_i`.
- `sample_o`  out  12  enveloped sample, to the mixer.
- `sample_valid_o`  out  1  qualifies `sample_o`.

## Operation
- Registers:
  - `volume` (12 bits).
  - `div_cnt` (RATE_W bits).
  - `prev_state` (3 bits).
- All three registers change only in cycles where `new_sample` is 1.
- On a tick:
  - `prev_state` is loaded with `state`.
  - If `state != prev_state` (phase change): `div_cnt` is cleared and no ramp step is taken. SUSTAIN and BLANK assignments still apply.
- Divider for ramping phases (ATTACK, DECAY, RELEASE):
  - If `div_cnt >= rate` of the current phase: apply one step, clear `div_cnt`, pulse `step_tick`.
  - Otherwise increment `div_cnt`.
  - Rate 0 therefore steps on every tick.
- Per-phase behaviour:
  - ATTACK: `volume + attack_step` computed at 13 bits, clamped to `VOL_MAX`.
  - DECAY: if `volume <= sustain_value`, or `volume - decay_step` is less than `sustain_value` or underflows, load `sustain_value`. Otherwise `volume - decay_step`.
  - SUSTAIN: `volume <= sustain_value` on every tick, so it tracks live edits.
  - RELEASE: `volume - release_step`, floored at 0.
  - BLANK: `volume <= 0`.
  - Codes 0, 6, 7: hold `volume` and `div_cnt`.
- A retrigger (any phase to ATTACK) ramps up from the current `volume`. There is no reset to 0, which avoids clicks.
- A step size of 0 leaves `volume` unchanged. The controller then remains in that phase by design; this is not an error.
- Clamps keep `volume[11]` at 0 whenever `VOL_MAX` is 12'h7FF.
- Gain path, 2-stage pipeline:
  - Stage 1 registers `prod = sample_i * volume` (24 bits) and the valid bit.
  - Stage 2 registers `sample_o = prod[22:11]` (truncate, no rounding) and `sample_valid_o`.
  - Stage 1 uses the `volume` register value current in the cycle `sample_valid_i` is high.

## Timing
- Reset values: `volume` 0, `div_cnt` 0, `prev_state` 5 (BLANK), `step_tick` 0, pipeline products 0, `sample_o` 0, `sample_valid_o` 0.
- `volume` updates on the clock edge of the `new_sample` cycle and is visible one cycle later. The controller consumes it on the following tick, so there is one sample period of loop delay.
- `step_tick` is high for exactly that same update cycle's following clock, one cycle wide.
- Gain latency is 2 cycles from `sample_valid_i` to `sample_valid_o`, fully pipelined, one sample per cycle.
- If `new_sample` and `sample_valid_i` are high in the same cycle, stage 1 uses the pre-update `volume`.
- `RST` mid-ramp takes priority over `new_sample`. Both pipeline valid bits are cleared that cycle, so in-flight samples are dropped.
- `state` is sampled only on ticks; changes between ticks are ignored until the next tick.

## Structure
- Shared package/include `envelope_defs`:
  - Phase codes ATTACK through BLANK.
  - `VOLUME_RESET` and `VOLUME_MAX`.
  - `ENV_W` = 12.
  - `ENVELOPE_CTRL12` moves to these shared definitions as well.
- Natural sub-module: `env_vca12`, the 2-stage multiply/truncate gain path with valid pipeline. The ramp FSM stays in the top level.

## Test plan
- **Reset:** hold `RST` 3 cycles with ticks and valid samples present -> all outputs 0; `prev_state` = BLANK.
- **Attack:** `state` = 1 from BLANK, `attack_rate` 0, `attack_step` 0x80.
  - First tick is a phase change: `volume` stays 0.
  - Subsequent ticks: 0x080, 0x100, … 0x780, then 0x7FF and held.
- **Decay:** `volume` 0x7FF, `state` = 2, `decay_rate` 1, `decay_step` 0x40, `sustain_value` 0x030.
  - `volume` drops 0x40 every second tick.
  - Last step clamps to exactly 0x030; `step_tick` is seen once per step.
- **Release with retrigger:**
  - `volume` 0x050, `state` = 4, `release_step` 0x20 -> 0x030, 0x010, 0x000, then holds 0.
  - Repeat from 0x300 and switch to `state` = 1 -> one tick at 0x300, then rises from 0x300.
- **Gain:**
  - `volume` 0x7FF with `sample_i` 0xFFF -> `sample_o` 0xFFD two cycles later.
  - `volume` 0x400 with `sample_i` 0x800 -> 0x400.
  - Back-to-back valids stream without bubbles.
- **Simultaneous events:** `RST` asserted in the same cycle as `new_sample` and `sample_valid_i` -> no step, `sample_valid_o` stays 0 for the next 2 cycles.

Source files
------------

// File: rtl/envelope_defs_pkg.sv
// Shared envelope definitions: phase codes, volume limits and ramp step arithmetic.
// Used by the ramp datapath and its gain stage (and by the envelope controller).
package envelope_defs_pkg;

  localparam int unsigned ENV_W  = 12;
  localparam int unsigned STEP_W = 8;
  localparam int unsigned PROD_W = 2 * ENV_W;

  localparam logic [ENV_W-1:0] VOLUME_RESET = 12'h000;
  localparam logic [ENV_W-1:0] VOLUME_MAX   = 12'h7FF;

  typedef enum logic [2:0] {
    PH_NONE    = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4,
    PH_BLANK   = 3'd5
  } phase_t;

  typedef struct packed {
    logic              valid;
    logic [PROD_W-1:0] prod;
  } gain_stage_t;

  function automatic logic [ENV_W-1:0] attack_next(input logic [ENV_W-1:0]  vol,
                                                   input logic [STEP_W-1:0] step,
                                                   input logic [ENV_W-1:0]  vmax);
    logic [ENV_W:0] sum;
    sum = (ENV_W+1)'(vol) + (ENV_W+1)'(step);
    if (sum > (ENV_W+1)'(vmax)) return vmax;
    return sum[ENV_W-1:0];
  endfunction

  // Lands exactly on the sustain level instead of overshooting or wrapping.
  function automatic logic [ENV_W-1:0] decay_next(input logic [ENV_W-1:0]  vol,
                                                  input logic [STEP_W-1:0] step,
                                                  input logic [ENV_W-1:0]  sus);
    logic [ENV_W:0] diff;
    diff = (ENV_W+1)'(vol) - (ENV_W+1)'(step);
    if ((vol <= sus) || diff[ENV_W] || (diff[ENV_W-1:0] < sus)) return sus;
    return diff[ENV_W-1:0];
  endfunction

  function automatic logic [ENV_W-1:0] release_next(input logic [ENV_W-1:0]  vol,
                                                    input logic [STEP_W-1:0] step);
    if (vol < ENV_W'(step)) return VOLUME_RESET;
    return vol - ENV_W'(step);
  endfunction

endpackage

// File: rtl/env_vca12.sv
// Two-stage gain path: sample * volume registered, then truncated to 12 bits.
// Valid travels alongside; reset drops anything in flight.
module env_vca12
  import envelope_defs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ENV_W-1:0] sample_i,
  input  logic             sample_valid_i,
  input  logic [ENV_W-1:0] volume,
  output logic [ENV_W-1:0] sample_o,
  output logic             sample_valid_o
);

  gain_stage_t s1;
  logic        unused_prod;

  // Full-scale volume is 0x7FF, so the useful product bits sit just below the MSB.
  assign unused_prod = ^{s1.prod[PROD_W-1], s1.prod[ENV_W-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1             <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
    end else begin
      s1.valid <= sample_valid_i;
      if (sample_valid_i) s1.prod <= PROD_W'(sample_i) * PROD_W'(volume);
      sample_valid_o <= s1.valid;
      if (s1.valid) sample_o <= s1.prod[PROD_W-2:ENV_W-1];
    end
  end

endmodule

// File: rtl/envelope_ramp12.sv
// Per-voice envelope ramp: steps volume on new_sample ticks according to the
// controller's phase code, and applies it to the oscillator sample.
module envelope_ramp12
  import envelope_defs_pkg::*;
#(
  parameter logic [ENV_W-1:0] VOL_MAX = 12'h7FF,
  parameter int unsigned      RATE_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              new_sample,
  input  logic [2:0]        state,
  input  logic [RATE_W-1:0] attack_rate,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [RATE_W-1:0] release_rate,
  input  logic [STEP_W-1:0] attack_step,
  input  logic [STEP_W-1:0] decay_step,
  input  logic [STEP_W-1:0] release_step,
  input  logic [ENV_W-1:0]  sustain_value,
  output logic [ENV_W-1:0]  volume,
  output logic              step_tick,
  input  logic [ENV_W-1:0]  sample_i,
  input  logic              sample_valid_i,
  output logic [ENV_W-1:0]  sample_o,
  output logic              sample_valid_o
);

  phase_t            prev_state;
  phase_t            prev_nxt;
  phase_t            cur;
  logic [RATE_W-1:0] div_cnt;
  logic [RATE_W-1:0] div_nxt;
  logic [RATE_W-1:0] rate_sel;
  logic [ENV_W-1:0]  vol_nxt;
  logic [ENV_W-1:0]  stepped;
  logic              tick_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      volume     <= VOLUME_RESET;
      div_cnt    <= '0;
      prev_state <= PH_BLANK;
      step_tick  <= 1'b0;
    end else begin
      volume     <= vol_nxt;
      div_cnt    <= div_nxt;
      prev_state <= prev_nxt;
      step_tick  <= tick_nxt;
    end
  end

  // Per-phase rate and candidate stepped volume.
  always_comb begin
    cur      = phase_t'(state);
    rate_sel = '0;
    stepped  = volume;
    case (cur)
      PH_ATTACK: begin
        rate_sel = attack_rate;
        stepped  = attack_next(volume, attack_step, VOL_MAX);
      end
      PH_DECAY: begin
        rate_sel = decay_rate;
        stepped  = decay_next(volume, decay_step, sustain_value);
      end
      PH_RELEASE: begin
        rate_sel = release_rate;
        stepped  = release_next(volume, release_step);
      end
      default: ;
    endcase
  end

  // Next-state: only ticks touch the registers; a phase change restarts the divider.
  always_comb begin
    vol_nxt  = volume;
    div_nxt  = div_cnt;
    prev_nxt = prev_state;
    tick_nxt = 1'b0;
    if (new_sample) begin
      prev_nxt = cur;
      if (cur != prev_state) begin
        div_nxt = '0;
        if (cur == PH_SUSTAIN)    vol_nxt = sustain_value;
        else if (cur == PH_BLANK) vol_nxt = VOLUME_RESET;
      end else begin
        case (cur)
          PH_ATTACK, PH_DECAY, PH_RELEASE: begin
            if (div_cnt >= rate_sel) begin
              div_nxt  = '0;
              tick_nxt = 1'b1;
              vol_nxt  = stepped;
            end else begin
              div_nxt = div_cnt + RATE_W'(1);
            end
          end
          PH_SUSTAIN: vol_nxt = sustain_value;
          PH_BLANK:   vol_nxt = VOLUME_RESET;
          default: ;
        endcase
      end
    end
  end

  env_vca12 u_vca (
    .clk            (CLK),
    .rst            (RST),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .volume         (volume),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o)
  );

endmodule
